// File: rtl/axi_cdc_isolate_ctrl.sv
// Isolation controller in front of an AXI CDC source stage: drains outstanding traffic, then fences the port.
// Latency: zero -- ungated channels pass straight through; isolate_o/isolated_o decode the registered state.
// Backpressure: a gated channel shows valid=0 downstream and ready=0 upstream; a held AW/AR is never withdrawn.
// Build option: define AXI_CDC_ISOLATE_TIMEOUT_EN to add the DRAIN timeout counter and drain_timeout_o.

// Minimal AXI request/response types so the block elaborates on its own;
// integrations override axi_req_t/axi_resp_t with their full channel structs.
package axi_cdc_isolate_pkg;
  typedef struct packed {
    logic [7:0] aw_addr;
    logic       aw_valid;
    logic [7:0] w_data;
    logic       w_last;
    logic       w_valid;
    logic       b_ready;
    logic [7:0] ar_addr;
    logic       ar_valid;
    logic       r_ready;
  } iso_axi_req_t;

  typedef struct packed {
    logic       aw_ready;
    logic       w_ready;
    logic [1:0] b_resp;
    logic       b_valid;
    logic       ar_ready;
    logic [7:0] r_data;
    logic       r_last;
    logic       r_valid;
  } iso_axi_resp_t;
endpackage

module axi_cdc_isolate_ctrl #(
  parameter int unsigned MaxTxns      = 8,
  parameter int unsigned DrainTimeout = 1024,
  parameter type         axi_req_t    = axi_cdc_isolate_pkg::iso_axi_req_t,
  parameter type         axi_resp_t   = axi_cdc_isolate_pkg::iso_axi_resp_t
) (
  input  logic      src_clk_i,
  input  logic      src_rst_i,
  input  logic      isolate_req_i,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i,
  output logic      isolate_o,
  output logic      isolated_o,
  output logic      drain_timeout_o
);

  localparam int unsigned    CntW   = $clog2(MaxTxns + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTxns);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {RUN, DRAIN, ISOLATED} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wr_cnt, rd_cnt, w_cnt;
  logic            aw_hold, ar_hold;

  logic iso, idle;
  logic aw_open, ar_open, w_open;
  logic aw_fwd, ar_fwd;
  logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;

  assign iso  = (state_q == ISOLATED);
  assign idle = (wr_cnt == '0) && (rd_cnt == '0) && (w_cnt == '0) && !aw_hold && !ar_hold;

  // A held address keeps its path open whatever the state, so valid never drops before the handshake.
  assign aw_open = !iso && (aw_hold || ((state_q == RUN) && (wr_cnt != CntMax) && (w_cnt != CntMax)));
  assign ar_open = !iso && (ar_hold || ((state_q == RUN) && (rd_cnt != CntMax)));

  assign aw_fwd = slv_req_i.aw_valid & aw_open;
  assign ar_fwd = slv_req_i.ar_valid & ar_open;
  assign aw_hs  = aw_fwd & mst_resp_i.aw_ready;
  assign ar_hs  = ar_fwd & mst_resp_i.ar_ready;

  // W data may only follow an address already accepted, or one accepted this very cycle.
  assign w_open    = !iso && ((w_cnt != '0) || aw_hs);
  assign w_last_hs = slv_req_i.w_valid & w_open & mst_resp_i.w_ready & slv_req_i.w_last;
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready & !iso;
  assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & !iso & mst_resp_i.r_last;

  // Pass payloads through untouched and overlay the gated valid/ready bits.
  always_comb begin
    mst_req_o            = slv_req_i;
    slv_resp_o           = mst_resp_i;
    mst_req_o.aw_valid   = aw_fwd;
    slv_resp_o.aw_ready  = mst_resp_i.aw_ready & aw_open;
    mst_req_o.w_valid    = slv_req_i.w_valid & w_open;
    slv_resp_o.w_ready   = mst_resp_i.w_ready & w_open;
    mst_req_o.ar_valid   = ar_fwd;
    slv_resp_o.ar_ready  = mst_resp_i.ar_ready & ar_open;
    slv_resp_o.b_valid   = mst_resp_i.b_valid & !iso;
    mst_req_o.b_ready    = slv_req_i.b_ready & !iso;
    slv_resp_o.r_valid   = mst_resp_i.r_valid & !iso;
    mst_req_o.r_ready    = slv_req_i.r_ready & !iso;
  end

  // Next-state: drain on request, fence once nothing is in flight, release whenever the request drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (isolate_req_i) state_d = DRAIN;
      DRAIN:    if (!isolate_req_i) state_d = RUN;
                else if (idle)      state_d = ISOLATED;
      ISOLATED: if (!isolate_req_i) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge src_clk_i) begin
    if (src_rst_i) state_q <= RUN;
    else           state_q <= state_d;
  end

  // Outstanding-transaction counters; simultaneous increment and decrement cancel out.
  always_ff @(posedge src_clk_i) begin
    if (src_rst_i) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      w_cnt  <= '0;
    end else begin
      if (aw_hs && !b_hs)           wr_cnt <= wr_cnt + CntOne;
      else if (b_hs && !aw_hs)      wr_cnt <= wr_cnt - CntOne;
      if (ar_hs && !r_last_hs)      rd_cnt <= rd_cnt + CntOne;
      else if (r_last_hs && !ar_hs) rd_cnt <= rd_cnt - CntOne;
      if (aw_hs && !w_last_hs)      w_cnt  <= w_cnt + CntOne;
      else if (w_last_hs && !aw_hs) w_cnt  <= w_cnt - CntOne;
    end
  end

  // Remember an address presented downstream but not yet accepted.
  always_ff @(posedge src_clk_i) begin
    if (src_rst_i) begin
      aw_hold <= 1'b0;
      ar_hold <= 1'b0;
    end else begin
      if (aw_hs)       aw_hold <= 1'b0;
      else if (aw_fwd) aw_hold <= 1'b1;
      if (ar_hs)       ar_hold <= 1'b0;
      else if (ar_fwd) ar_hold <= 1'b1;
    end
  end

  assign isolate_o  = iso;
  assign isolated_o = iso;

`ifdef AXI_CDC_ISOLATE_TIMEOUT_EN
  localparam int unsigned     TmoW    = $clog2(DrainTimeout + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(DrainTimeout - 1);

  logic [TmoW-1:0] tmo_cnt;

  // Count completed DRAIN cycles, saturating so the flag stays up until DRAIN is left.
  always_ff @(posedge src_clk_i) begin
    if (src_rst_i || (state_q != DRAIN)) tmo_cnt <= '0;
    else if (tmo_cnt != TmoLast)         tmo_cnt <= tmo_cnt + TmoW'(1);
  end

  assign drain_timeout_o = (state_q == DRAIN) && (tmo_cnt == TmoLast);
`else
  assign drain_timeout_o = 1'b0;
`endif

  // A zero timeout or zero transaction budget is a configuration error.
  a_cfg: assert property (@(posedge src_clk_i) (DrainTimeout > 0) && (MaxTxns > 0));

  // Responses without a matching request would wrap a counter below zero.
  a_wr_underflow: assert property (@(posedge src_clk_i) disable iff (src_rst_i)
                                   !(b_hs && !aw_hs && (wr_cnt == '0)));
  a_rd_underflow: assert property (@(posedge src_clk_i) disable iff (src_rst_i)
                                   !(r_last_hs && !ar_hs && (rd_cnt == '0)));
  a_w_underflow:  assert property (@(posedge src_clk_i) disable iff (src_rst_i)
                                   !(w_last_hs && !aw_hs && (w_cnt == '0)));

endmodule

// File: tb/tb_axi_cdc_isolate_ctrl.sv
// Bench for axi_cdc_isolate_ctrl: vector table, hand-written corner sequences, randomized run vs a reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The drain-timeout expectations follow AXI_CDC_ISOLATE_TIMEOUT_EN when the bench is built with it.
module tb_axi_cdc_isolate_ctrl;
  import axi_cdc_isolate_pkg::*;

  localparam int MT = 3;
  localparam int DT = 16;
`ifdef AXI_CDC_ISOLATE_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          iso_req;
  iso_axi_req_t  slv_req, mst_req;
  iso_axi_resp_t slv_resp, mst_resp;
  logic          isolate, isolated, dto;

  int errors = 0;
  int checks = 0;

  axi_cdc_isolate_ctrl #(
    .MaxTxns      (MT),
    .DrainTimeout (DT),
    .axi_req_t    (iso_axi_req_t),
    .axi_resp_t   (iso_axi_resp_t)
  ) dut (
    .src_clk_i       (clk),
    .src_rst_i       (rst),
    .isolate_req_i   (iso_req),
    .slv_req_i       (slv_req),
    .slv_resp_o      (slv_resp),
    .mst_req_o       (mst_req),
    .mst_resp_i      (mst_resp),
    .isolate_o       (isolate),
    .isolated_o      (isolated),
    .drain_timeout_o (dto)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    slv_req         = '0;
    slv_req.b_ready = 1'b1;
    slv_req.r_ready = 1'b1;
    mst_resp        = '0;
  endtask

  task automatic do_reset();
    idle();
    iso_req = 1'b0;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {29'd0, isolate, isolated, dto}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Advance to the next drive point (just after a rising edge) with idle inputs.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  // ---------------------------------------------------------------- vectors
  // in  = {req, aw_valid, aw_ready, w_valid, w_last, w_ready, ar_valid, ar_ready, b_valid, r_valid, r_last}
  // exp = {mst aw_valid, slv aw_ready, mst w_valid, mst ar_valid, slv ar_ready, slv b_valid, slv r_valid, isolated}
  typedef struct {
    logic [10:0] in;
    logic [7:0]  exp;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl[NV];

  task automatic run_table();
    logic [7:0] act;
    tbl[0]  = '{11'b0_00_000_00_0_00, 8'b0000_0000}; // idle after reset
    tbl[1]  = '{11'b0_10_111_00_0_00, 8'b1000_0000}; // AW stalls downstream; W without AW gated
    tbl[2]  = '{11'b1_10_000_00_0_00, 8'b1000_0000}; // isolation requested while AW held
    tbl[3]  = '{11'b1_11_111_11_0_00, 8'b1110_0000}; // DRAIN: held AW completes with W; new AR gated
    tbl[4]  = '{11'b1_11_000_00_0_00, 8'b0000_0000}; // DRAIN: fresh AW gated
    tbl[5]  = '{11'b1_00_000_00_1_00, 8'b0000_0100}; // B returns
    tbl[6]  = '{11'b1_00_000_00_0_00, 8'b0000_0000}; // all drained, still DRAIN this cycle
    tbl[7]  = '{11'b1_11_111_11_1_11, 8'b0000_0001}; // ISOLATED: everything blocked
    tbl[8]  = '{11'b0_11_111_11_1_11, 8'b0000_0001}; // request dropped, still ISOLATED this cycle
    tbl[9]  = '{11'b0_11_111_11_0_00, 8'b1111_1000}; // RUN again: traffic flows
    tbl[10] = '{11'b0_00_000_11_0_00, 8'b0001_1000}; // second outstanding AR
    tbl[11] = '{11'b0_00_000_11_0_00, 8'b0001_1000}; // third outstanding AR
    tbl[12] = '{11'b0_00_000_11_0_00, 8'b0000_0000}; // read budget exhausted
    tbl[13] = '{11'b0_00_000_11_0_11, 8'b0000_0010}; // R last returns, AR still blocked this cycle
    tbl[14] = '{11'b0_00_000_11_0_00, 8'b0001_1000}; // AR accepted again
    tbl[15] = '{11'b0_00_111_00_0_00, 8'b0000_0000}; // W with no open write gated
    for (int i = 0; i < NV; i++) begin
      next_cycle();
      {iso_req, slv_req.aw_valid, mst_resp.aw_ready, slv_req.w_valid, slv_req.w_last,
       mst_resp.w_ready, slv_req.ar_valid, mst_resp.ar_ready, mst_resp.b_valid,
       mst_resp.r_valid, mst_resp.r_last} = tbl[i].in;
      @(negedge clk);
      act = {mst_req.aw_valid, slv_resp.aw_ready, mst_req.w_valid, mst_req.ar_valid,
             slv_resp.ar_ready, slv_resp.b_valid, slv_resp.r_valid, isolated};
      check($sformatf("vec%0d", i), {24'd0, act}, {24'd0, tbl[i].exp});
      check($sformatf("vec%0d_isolate", i), {31'd0, isolate}, {31'd0, tbl[i].exp[0]});
    end
  endtask

  // -------------------------------------------------- drain with 3 writes
  task automatic seq_three_writes();
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      slv_req.aw_valid = 1'b1; slv_req.aw_addr = 8'(k);
      slv_req.w_valid  = 1'b1; slv_req.w_last  = 1'b1;
      mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
      @(negedge clk);
      check($sformatf("wr%0d_aw_fwd", k), {31'd0, mst_req.aw_valid & slv_resp.aw_ready}, 32'd1);
      check($sformatf("wr%0d_w_fwd", k), {31'd0, mst_req.w_valid}, 32'd1);
    end
    next_cycle();
    slv_req.aw_valid = 1'b1; mst_resp.aw_ready = 1'b1;
    @(negedge clk);
    check("wr_budget_full", {31'd0, mst_req.aw_valid}, 32'd0);
    next_cycle();
    iso_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      iso_req = 1'b1; mst_resp.b_valid = 1'b1;
      @(negedge clk);
      check($sformatf("b%0d_fwd", k), {31'd0, slv_resp.b_valid}, 32'd1);
    end
    next_cycle();
    iso_req = 1'b1;
    @(negedge clk);
    check("wr_zero_cycle_not_isolated", {31'd0, isolated}, 32'd0);
    next_cycle();
    iso_req = 1'b1;
    @(negedge clk);
    check("isolated_after_drain", {30'd0, isolate, isolated}, 32'd3);
  endtask

  // -------------------------------------------------- drain timeout
  task automatic seq_timeout();
    next_cycle();
    slv_req.aw_valid = 1'b1; slv_req.w_valid = 1'b1; slv_req.w_last = 1'b1;
    mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
    next_cycle();
    iso_req = 1'b1;
    for (int d = 1; d <= 23; d++) begin
      next_cycle();
      iso_req = 1'b1;
      mst_resp.b_valid = (d == 21);
      @(negedge clk);
      if (d <= 22)
        check($sformatf("timeout_drain_cycle%0d", d), {31'd0, dto}, {31'd0, TmoEn && (d >= DT)});
      else
        check("timeout_clears_on_exit", {30'd0, dto, isolated}, 32'd1);
    end
  endtask

  // -------------------------------------------------- reset in the middle of a drain
  task automatic seq_reset_mid_drain();
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      slv_req.aw_valid = 1'b1; mst_resp.aw_ready = 1'b1;
    end
    next_cycle();
    iso_req = 1'b1;
    next_cycle();
    iso_req = 1'b1;
    @(negedge clk);
    check("pre_reset_draining", {31'd0, isolated}, 32'd0);
    next_cycle();
    iso_req = 1'b1; rst = 1'b1;
    next_cycle();
    rst = 1'b0; iso_req = 1'b0;
    slv_req.w_valid = 1'b1; slv_req.w_last = 1'b1; mst_resp.w_ready = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {29'd0, isolate, isolated, dto}, 32'd0);
    check("post_reset_w_gated", {31'd0, mst_req.w_valid}, 32'd0);
    next_cycle();
    iso_req = 1'b1;
    next_cycle();
    iso_req = 1'b1;
    @(negedge clk);
    check("post_reset_drain", {31'd0, isolated}, 32'd0);
    next_cycle();
    iso_req = 1'b1;
    @(negedge clk);
    check("post_reset_nothing_outstanding", {31'd0, isolated}, 32'd1);
  endtask

  // -------------------------------------------------- randomized run
  // The model tracks modes (0 RUN, 1 DRAIN, 2 ISOLATED) and outstanding counts.
  task automatic rand_test(input int n);
    int mode = 0, n_wr = 0, n_rd = 0, n_w = 0, dcyc = 0;
    bit aw_pend = 0, ar_pend = 0;
    for (int c = 0; c < n; c++) begin
      bit quiet, may_aw, may_ar, aw_hs, ar_hs, w_ok, wl_hs, b_hs, rl_hs;
      int nmode;
      logic [11:0] exp, act;
      logic [7:0] aw_a, w_d, r_d;
      @(posedge clk);
      #1;
      if ($urandom_range(9) == 0) iso_req = ~iso_req;
      if (!aw_pend) begin
        slv_req.aw_valid = 1'($urandom_range(1));
        slv_req.aw_addr  = 8'($urandom);
      end
      if (!ar_pend) begin
        slv_req.ar_valid = 1'($urandom_range(1));
        slv_req.ar_addr  = 8'($urandom);
      end
      slv_req.w_valid   = 1'($urandom_range(1));
      slv_req.w_last    = 1'($urandom_range(1));
      slv_req.w_data    = 8'($urandom);
      slv_req.b_ready   = 1'($urandom_range(1));
      slv_req.r_ready   = 1'($urandom_range(1));
      mst_resp.aw_ready = 1'($urandom_range(1));
      mst_resp.w_ready  = 1'($urandom_range(1));
      mst_resp.ar_ready = 1'($urandom_range(1));
      mst_resp.b_valid  = (n_wr > n_w) ? 1'($urandom_range(1)) : 1'b0;
      mst_resp.r_valid  = (n_rd > 0) ? 1'($urandom_range(1)) : 1'b0;
      mst_resp.r_last   = 1'($urandom_range(1));
      mst_resp.r_data   = 8'($urandom);
      aw_a = slv_req.aw_addr; w_d = slv_req.w_data; r_d = mst_resp.r_data;

      quiet  = (mode == 2);
      may_aw = aw_pend || (mode == 0 && n_wr < MT && n_w < MT);
      may_ar = ar_pend || (mode == 0 && n_rd < MT);
      aw_hs  = slv_req.aw_valid && may_aw && mst_resp.aw_ready;
      ar_hs  = slv_req.ar_valid && may_ar && mst_resp.ar_ready;
      w_ok   = !quiet && (n_w > 0 || aw_hs);
      wl_hs  = w_ok && slv_req.w_valid && mst_resp.w_ready && slv_req.w_last;
      b_hs   = !quiet && mst_resp.b_valid && slv_req.b_ready;
      rl_hs  = !quiet && mst_resp.r_valid && slv_req.r_ready && mst_resp.r_last;
      exp = {slv_req.aw_valid && may_aw, mst_resp.aw_ready && may_aw,
             slv_req.w_valid && w_ok, mst_resp.w_ready && w_ok,
             slv_req.ar_valid && may_ar, mst_resp.ar_ready && may_ar,
             mst_resp.b_valid && !quiet, slv_req.b_ready && !quiet,
             mst_resp.r_valid && !quiet, slv_req.r_ready && !quiet,
             quiet, quiet};

      @(negedge clk);
      act = {mst_req.aw_valid, slv_resp.aw_ready, mst_req.w_valid, slv_resp.w_ready,
             mst_req.ar_valid, slv_resp.ar_ready, slv_resp.b_valid, mst_req.b_ready,
             slv_resp.r_valid, mst_req.r_ready, isolate, isolated};
      check($sformatf("rand%0d_handshakes", c), {20'd0, act}, {20'd0, exp});
      check($sformatf("rand%0d_payload_timeout", c),
            {7'd0, mst_req.aw_addr, mst_req.w_data, slv_resp.r_data, dto},
            {7'd0, aw_a, w_d, r_d, TmoEn && mode == 1 && dcyc >= DT});

      nmode = mode;
      if (mode == 0 && iso_req) nmode = 1;
      else if (mode == 1 && !iso_req) nmode = 0;
      else if (mode == 1 && n_wr == 0 && n_rd == 0 && n_w == 0 && !aw_pend && !ar_pend) nmode = 2;
      else if (mode == 2 && !iso_req) nmode = 0;
      dcyc = (nmode == 1) ? ((mode == 1) ? dcyc + 1 : 1) : 0;
      mode = nmode;
      n_wr += int'(aw_hs) - int'(b_hs);
      n_rd += int'(ar_hs) - int'(rl_hs);
      n_w  += int'(aw_hs) - int'(wl_hs);
      aw_pend = !aw_hs && slv_req.aw_valid && may_aw;
      ar_pend = !ar_hs && slv_req.ar_valid && may_ar;
    end
  endtask

  initial begin
    rst = 1'b1;
    iso_req = 1'b0;
    idle();
    do_reset();
    run_table();
    do_reset();
    seq_three_writes();
    do_reset();
    seq_timeout();
    do_reset();
    seq_reset_mid_drain();
    do_reset();
    rand_test(3000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
